// File: rtl/clk_div_pkg.sv
// Shared defaults and helpers for the clock-divider bank.
package clk_div_pkg;

    localparam int unsigned DEF_DIV_W   = 8;
    localparam int unsigned DEF_RST_DIV = 2;

    // Number of high cycles in a period of length d.
    function automatic int unsigned half_up(input int unsigned d);
        return (d + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable divider channel: counter, current/pending divisor and registered outputs.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    input  logic             sync_clr,
    output logic             clk_out,
    output logic             tick,
    output logic [DIV_W-1:0] cur_div
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             pend_full_q, pend_full_d;
    logic             run_q;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;

    logic             accept;
    logic             parked;
    logic             period_end;
    logic             boundary;
    logic [DIV_W-1:0] new_div;

    assign accept     = div_valid & ~pend_full_q;
    assign parked     = (cur_div_q == '0);
    assign period_end = ~parked & (cnt_q == cur_div_q - DIV_W'(1));
    // A parked channel treats a pending divisor as an immediate boundary.
    assign boundary   = ~run_q | sync_clr | period_end | (parked & pend_full_q);
    assign new_div    = pend_full_q ? pend_q : cur_div_q;

    always_comb begin
        cnt_d       = cnt_q;
        cur_div_d   = cur_div_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        clk_out_d   = 1'b0;
        tick_d      = 1'b0;
        if (boundary) begin
            cur_div_d   = new_div;
            pend_full_d = 1'b0;
            cnt_d       = '0;
            clk_out_d   = (new_div != '0);
            tick_d      = (new_div != '0);
        end else if (!parked) begin
            cnt_d     = cnt_q + DIV_W'(1);
            clk_out_d = (32'(cnt_d) < half_up(32'(cur_div_q)));
        end else begin
            cnt_d = '0;
        end
        // Accepted value is only ever held pending; it never applies on its own edge.
        if (accept) begin
            pend_d      = div_in;
            pend_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cur_div_q   <= DIV_W'(RST_DIV);
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            run_q       <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            cur_div_q   <= cur_div_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            run_q       <= 1'b1;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
        end
    end

    assign div_ready = ~pend_full_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign cur_div   = cur_div_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent programmable clock dividers sharing one clock and a phase-align strobe.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned DIV_W   = DEF_DIV_W,
    parameter int unsigned RST_DIV = DEF_RST_DIV
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*DIV_W-1:0] div_in,
    input  logic [NUM_CH-1:0]       div_valid,
    output logic [NUM_CH-1:0]       div_ready,
    input  logic                    sync_clr,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH*DIV_W-1:0] cur_div
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        clk_div_chan #(
            .DIV_W   (DIV_W),
            .RST_DIV (RST_DIV)
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .div_in    (div_in[c*DIV_W +: DIV_W]),
            .div_valid (div_valid[c]),
            .div_ready (div_ready[c]),
            .sync_clr  (sync_clr),
            .clk_out   (clk_out[c]),
            .tick      (tick[c]),
            .cur_div   (cur_div[c*DIV_W +: DIV_W])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Scoreboard bench for clk_div_bank: a phase-based reference model queues expected outputs per edge.
module tb_clk_div_bank;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int RD  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH*DW-1:0] div_in;
    logic [NCH-1:0]    div_valid;
    logic [NCH-1:0]    div_ready;
    logic              sync_clr;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    tick;
    logic [NCH*DW-1:0] cur_div;

    typedef struct packed {
        logic [NCH-1:0]    clk_out;
        logic [NCH-1:0]    tick;
        logic [NCH*DW-1:0] cur_div;
        logic [NCH-1:0]    ready;
    } exp_t;

    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: phase, divisor in effect, pending slot.
    int m_p[NCH];
    int m_d[NCH];
    int m_pend[NCH];
    bit m_full[NCH];
    bit m_run;

    clk_div_bank #(
        .NUM_CH  (NCH),
        .DIV_W   (DW),
        .RST_DIV (RD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .sync_clr  (sync_clr),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_p[c]    = 0;
            m_d[c]    = RD;
            m_pend[c] = 0;
            m_full[c] = 1'b0;
        end
    endtask

    task automatic model_advance();
        for (int c = 0; c < NCH; c++) begin
            bit acc;
            bit bnd;
            acc = div_valid[c] && !m_full[c];
            if (!m_run) bnd = 1'b1;
            else bnd = sync_clr || (m_d[c] != 0 && m_p[c] == m_d[c] - 1) ||
                       (m_d[c] == 0 && m_full[c]);
            if (bnd) begin
                if (m_full[c]) begin
                    m_d[c]    = m_pend[c];
                    m_full[c] = 1'b0;
                end
                m_p[c] = 0;
            end else if (m_d[c] != 0) begin
                m_p[c]++;
            end
            if (acc) begin
                m_pend[c] = int'(div_in[c*DW +: DW]);
                m_full[c] = 1'b1;
            end
        end
        m_run = 1'b1;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        for (int c = 0; c < NCH; c++) begin
            e.clk_out[c]       = (m_d[c] != 0) && (m_p[c] < (m_d[c] + 1) / 2);
            e.tick[c]          = (m_d[c] != 0) && (m_p[c] == 0);
            e.cur_div[c*DW +: DW] = DW'(m_d[c]);
            e.ready[c]         = !m_full[c];
        end
        return e;
    endfunction

    // One clock: model predicts, DUT is sampled 1 time unit after the edge.
    task automatic step();
        exp_t e;
        model_advance();
        exp_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_eq("clk_out", 32'(clk_out), 32'(e.clk_out));
        check_eq("tick", 32'(tick), 32'(e.tick));
        check_eq("cur_div", 32'(cur_div), 32'(e.cur_div));
        check_eq("div_ready", 32'(div_ready), 32'(e.ready));
    endtask

    task automatic write_div(input int ch, input int val);
        bit done;
        done = 1'b0;
        div_in[ch*DW +: DW] = DW'(val);
        div_valid[ch] = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            done = !m_full[ch];
            step();
        end
        div_valid[ch] = 1'b0;
        if (!done) check_eq("write_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] pat;
        logic [11:0] pat2;

        rst       = 1'b1;
        div_in    = '0;
        div_valid = '0;
        sync_clr  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_clk_out", 32'(clk_out), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_cur_div", 32'(cur_div), 32'h0202);
        check_eq("rst_ready", 32'(div_ready), 32'd3);
        @(negedge clk);
        rst = 1'b0;

        // 1: default divide-by-2
        pat = '0; pat2 = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            pat  = {pat[10:0], clk_out[0]};
            pat2 = {pat2[10:0], tick[0]};
        end
        check_eq("t1_clk_pat", 32'(pat[3:0]), 32'hA);
        check_eq("t1_tick_pat", 32'(pat2[3:0]), 32'hA);

        // 2: divide-by-5 mid-period
        write_div(0, 5);
        repeat (14) step();

        // 3: divide-by-1, then park
        write_div(0, 1);
        repeat (6) step();
        write_div(0, 0);
        repeat (6) step();
        check_eq("t3_parked_div", 32'(cur_div[DW-1:0]), 32'd0);
        check_eq("t3_parked_clk", 32'(clk_out[0]), 32'd0);

        // 4: park ch1, then wake it with D=3
        write_div(1, 0);
        repeat (4) step();
        write_div(1, 3);
        pat = '0; pat2 = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            pat  = {pat[10:0], tick[1]};
            pat2 = {pat2[10:0], clk_out[1]};
        end
        check_eq("t4_tick_pat", 32'(pat[2:0]), 32'b100);
        check_eq("t4_clk_pat", 32'(pat2[2:0]), 32'b110);

        // 5: align D=4 and D=6 with sync_clr
        write_div(0, 4);
        write_div(1, 6);
        repeat (7) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        check_eq("t5_sync_tick", 32'(tick), 32'd3);
        pat = '0;
        for (int i = 0; i < 12; i++) begin
            step();
            pat = {pat[10:0], tick[1]};
        end
        check_eq("t5_ch1_ticks", 32'(pat), 32'b000001000001);

        // sync_clr coinciding with an accept: value stays pending
        div_in[DW +: DW] = DW'(2);
        div_valid[1] = 1'b1;
        sync_clr = 1'b1;
        step();
        div_valid[1] = 1'b0;
        sync_clr = 1'b0;
        check_eq("t5_sync_acc_div", 32'(cur_div[DW +: DW]), 32'd6);
        repeat (8) step();

        // 6: reset with D=7 running and a pending request
        write_div(0, 7);
        repeat (5) step();
        write_div(0, 9);
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        check_eq("t6_rst_clk_out", 32'(clk_out), 32'd0);
        check_eq("t6_rst_tick", 32'(tick), 32'd0);
        check_eq("t6_rst_cur_div", 32'(cur_div), 32'h0202);
        check_eq("t6_rst_ready", 32'(div_ready), 32'd3);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (12) step();
        check_eq("t6_no_pending", 32'(cur_div[DW-1:0]), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
